// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types and constants for the ASCON permutation.
// Holds the sequencer state enum, round counts and rcmode codes.
package ascon_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } perm_state_t;

  localparam logic [3:0] ROUNDS_A  = 4'd12;
  localparam logic [3:0] ROUNDS_B6 = 4'd6;
  localparam logic [3:0] ROUNDS_B8 = 4'd8;

  localparam logic [1:0] RC_HOLD = 2'b00;
  localparam logic [1:0] RC_STEP = 2'b01;
  localparam logic [1:0] RC_LOAD = 2'b10;

  function automatic logic rounds_legal(
    input logic [3:0] n
  );
    return (n == ROUNDS_A) ||
           (n == ROUNDS_B6) ||
           (n == ROUNDS_B8);
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: round sequencer for the ASCON permutation.
// Ports: clk, RST (async, active-high); start/nrounds/abort in;
// busy, round_en, first_round, last_round, done, err status out;
// rcmode/constti to the round-constant generator; round_idx count.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] nrounds,
  input  logic       abort,
  output logic       busy,
  output logic       round_en,
  output logic       first_round,
  output logic       last_round,
  output logic       done,
  output logic       err,
  output logic [1:0] rcmode,
  output logic [3:0] constti,
  output logic [3:0] round_idx
);

  localparam logic [3:0] STEP = 4'(UNROLL);

  perm_state_t state;
  perm_state_t state_nx;

  logic [3:0] n_q;
  logic [3:0] cti_q;
  logic [3:0] idx_q;
  logic       err_q;
  logic       run;
  logic       last;
  logic       accept;

  assign run    = (state == S_RUN);
  // Final RUN cycle: this cycle's rounds bring the count to N.
  assign last   = run && (idx_q == n_q - STEP);
  assign accept = (state == S_IDLE) && start &&
                  rounds_legal(nrounds);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_LOAD;
      S_LOAD: state_nx = S_RUN;
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      n_q   <= '0;
      cti_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start &&
               !rounds_legal(nrounds);
      if (accept) begin
        n_q   <= nrounds;
        cti_q <= ROUNDS_A - nrounds;
        idx_q <= '0;
      end else if (run) begin
        idx_q <= idx_q + STEP;
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign round_en    = run;
  assign first_round = run && (idx_q == 4'd0);
  assign last_round  = last;
  assign done        = (state == S_DONE);
  assign err         = err_q;
  assign constti     = cti_q;
  assign round_idx   = idx_q;

  // Hold on the final RUN cycle so the index never wraps past 11.
  always_comb begin
    rcmode = RC_HOLD;
    if (state == S_LOAD) begin
      rcmode = RC_LOAD;
    end else if (run && !last) begin
      rcmode = RC_STEP;
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl: directed bench for the round sequencer.
// Drives UNROLL=1 and UNROLL=2 instances side by side.
module tb_ascon_perm_ctrl;
  import ascon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RST;
  logic       start;
  logic       abort;
  logic [3:0] nrounds;

  logic       busy        [2];
  logic       round_en    [2];
  logic       first_round [2];
  logic       last_round  [2];
  logic       done        [2];
  logic       err         [2];
  logic [1:0] rcmode      [2];
  logic [3:0] constti     [2];
  logic [3:0] round_idx   [2];

  int tests = 0;
  int fails = 0;

  ascon_perm_ctrl #(.UNROLL(1)) dut1 (
    .clk(clk), .RST(RST), .start(start),
    .nrounds(nrounds), .abort(abort),
    .busy(busy[0]), .round_en(round_en[0]),
    .first_round(first_round[0]),
    .last_round(last_round[0]),
    .done(done[0]), .err(err[0]),
    .rcmode(rcmode[0]), .constti(constti[0]),
    .round_idx(round_idx[0])
  );

  ascon_perm_ctrl #(.UNROLL(2)) dut2 (
    .clk(clk), .RST(RST), .start(start),
    .nrounds(nrounds), .abort(abort),
    .busy(busy[1]), .round_en(round_en[1]),
    .first_round(first_round[1]),
    .last_round(last_round[1]),
    .done(done[1]), .err(err[1]),
    .rcmode(rcmode[1]), .constti(constti[1]),
    .round_idx(round_idx[1])
  );

  // Stand-in round-constant generators, one per instance.
  logic [3:0] gidx [2];
  always @(posedge clk or posedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) gidx[k] <= 4'd0;
      else if (rcmode[k] == RC_LOAD) gidx[k] <= constti[k];
      else if (rcmode[k] == RC_STEP)
        gidx[k] <= gidx[k] + 4'(k + 1);
    end
  end

  function automatic logic [7:0] rc_byte(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  typedef struct {
    logic [3:0] n;
    bit         legal;
    logic [3:0] cti;
    logic [7:0] rc_first;
    logic [7:0] rc_last1;
    logic [7:0] rc_last2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input int k, input int c,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u=%0d cyc=%0d got=%0h want=%0h",
               nm, k + 1, c, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_busy"}, k, 0, 16'(busy[k]), 16'd0);
      check({tag, "_ren"}, k, 0, 16'(round_en[k]), 16'd0);
      check({tag, "_first"}, k, 0, 16'(first_round[k]), 16'd0);
      check({tag, "_last"}, k, 0, 16'(last_round[k]), 16'd0);
      check({tag, "_done"}, k, 0, 16'(done[k]), 16'd0);
      check({tag, "_err"}, k, 0, 16'(err[k]), 16'd0);
      check({tag, "_rcm"}, k, 0, 16'(rcmode[k]), 16'd0);
      check({tag, "_cti"}, k, 0, 16'(constti[k]), 16'd0);
      check({tag, "_ridx"}, k, 0, 16'(round_idx[k]), 16'd0);
    end
  endtask

  // Expected outputs in cycle c of a legal run (cycle 1 = LOAD).
  task automatic check_cycle(input int k, input int n,
                             input logic [3:0] cti, input int c);
    int u, nc;
    logic b_e, re_e, f_e, l_e, d_e;
    logic [1:0] rc_e;
    u    = k + 1;
    nc   = n / u;
    b_e  = (c >= 1) && (c <= 2 + nc);
    re_e = (c >= 2) && (c <= 1 + nc);
    f_e  = (c == 2);
    l_e  = (c == 1 + nc);
    d_e  = (c == 2 + nc);
    rc_e = (c == 1) ? RC_LOAD :
           (re_e && !l_e) ? RC_STEP : RC_HOLD;
    check("busy", k, c, 16'(busy[k]), 16'(b_e));
    check("round_en", k, c, 16'(round_en[k]), 16'(re_e));
    check("first", k, c, 16'(first_round[k]), 16'(f_e));
    check("last", k, c, 16'(last_round[k]), 16'(l_e));
    check("done", k, c, 16'(done[k]), 16'(d_e));
    check("rcmode", k, c, 16'(rcmode[k]), 16'(rc_e));
    check("err", k, c, 16'(err[k]), 16'd0);
    if (c == 1)
      check("constti", k, c, 16'(constti[k]), 16'(cti));
    if (re_e) begin
      check("ridx_run", k, c, 16'(round_idx[k]),
            16'((c - 2) * u));
      check("rc_run", k, c, 16'(rc_byte(gidx[k])),
            16'(rc_byte(cti + 4'((c - 2) * u))));
    end
    if (c >= 2 + nc)
      check("ridx_end", k, c, 16'(round_idx[k]), 16'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (busy[0] || busy[1]); i++)
      @(negedge clk);
    check("idle_timeout", 0, 0,
          16'(busy[0] | busy[1]), 16'd0);
  endtask

  initial begin
    vecs[0] = '{4'd12, 1'b1, 4'd0, 8'hF0, 8'h4B, 8'h5A};
    vecs[1] = '{4'd6,  1'b1, 4'd6, 8'h96, 8'h4B, 8'h5A};
    vecs[2] = '{4'd8,  1'b1, 4'd4, 8'hB4, 8'h4B, 8'h5A};
    vecs[3] = '{4'd7,  1'b0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{4'd0,  1'b0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{4'd13, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{4'd15, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00};

    RST = 1'b1; start = 1'b0; abort = 1'b0; nrounds = 4'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    RST = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Table-driven runs; each start lands on the earliest legal cycle.
    for (int v = 0; v < 7; v++) begin
      start = 1'b1;
      nrounds = vecs[v].n;
      if (vecs[v].legal) begin
        for (int c = 1; c <= 3 + vecs[v].n; c++) begin
          @(negedge clk);
          if (c == 1) start = 1'b0;
          for (int k = 0; k < 2; k++) begin
            check_cycle(k, vecs[v].n, vecs[v].cti, c);
            if (c == 2)
              check("rc_first", k, c, 16'(rc_byte(gidx[k])),
                    16'(vecs[v].rc_first));
            if (c == 1 + vecs[v].n / (k + 1))
              check("rc_last", k, c, 16'(rc_byte(gidx[k])),
                    16'(k == 0 ? vecs[v].rc_last1
                               : vecs[v].rc_last2));
          end
        end
      end else begin
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
          check("err_pulse", k, 1, 16'(err[k]), 16'd1);
          check("err_busy", k, 1, 16'(busy[k]), 16'd0);
          check("err_rcm", k, 1, 16'(rcmode[k]), 16'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          check("err_clear", k, 2, 16'(err[k]), 16'd0);
          check("err_busy2", k, 2, 16'(busy[k]), 16'd0);
        end
      end
    end

    // Start ignored mid-run, then abort in RUN cycle 5.
    @(negedge clk);
    start = 1'b1;
    nrounds = 4'd12;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 6) begin
        for (int k = 0; k < 2; k++)
          check_cycle(k, 12, 4'd0, c);
      end else begin
        for (int k = 0; k < 2; k++) begin
          check("abort_busy", k, c, 16'(busy[k]), 16'd0);
          check("abort_ren", k, c, 16'(round_en[k]), 16'd0);
          check("abort_done", k, c, 16'(done[k]), 16'd0);
          check("abort_rcm", k, c, 16'(rcmode[k]), 16'd0);
        end
      end
      start = (c == 4);
      nrounds = (c == 4) ? 4'd6 : 4'd12;
      abort = (c == 6);
    end

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    nrounds = 4'd12;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++)
        check_cycle(k, 12, 4'd0, c);
    end
    #2 RST = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check_zero("rst_release");

    // Back-to-back: start held high, one done per run.
    start = 1'b1;
    nrounds = 4'd8;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int p;
        p = 8 / (k + 1) + 3;
        check("b2b_busy", k, c, 16'(busy[k]),
              16'((c % p) != 0));
        check("b2b_done", k, c, 16'(done[k]),
              16'((c % p) == p - 1));
        check("b2b_load", k, c, 16'(rcmode[k] == RC_LOAD),
              16'((c % p) == 1));
      end
    end
    start = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
